// File: rtl/rmw_ctrl_pkg.sv
// Shared constants and the pipeline stage record for the read-modify-write controller.
package rmw_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int NUM_STAGES = 4;

  // Default-width stage record; the top re-declares the same shape at its own widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/rmw_hazard_chk.sv
// Read-after-write hazard detector: flags an incoming address that matches a valid op in S1..S3.
module rmw_hazard_chk
  import rmw_ctrl_pkg::*;
#(
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter type entry_t = rmw_ctrl_pkg::stage_t
) (
  input  logic                        in_valid,
  input  logic [ADDR_W-1:0]           in_addr,
  input  entry_t [NUM_STAGES-2:0]     older,
  output logic                        hazard
);

  logic unused_data;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hazard      = 1'b0;
    unused_data = 1'b0;
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      unused_data = unused_data ^ (^older[i].data);
      if (in_valid && older[i].valid && (older[i].addr == in_addr)) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rmw_pipe_ctrl.sv
// 4-stage read-modify-write (data + 1) controller with RAW hazard stalling.
// Optional stall-cycle counter enabled by defining RMW_STALL_CNT_EN.
module rmw_pipe_ctrl
  import rmw_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_addr,
  output logic [DATA_W-1:0] done_data,
  output logic              busy,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pipe_stage_t;

  // st[0] is S1 ... st[3] is S4.
  pipe_stage_t [NUM_STAGES-1:0] st;

  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] s3_inc;

  // S4 is deliberately excluded: its write lands on the same edge a new op enters S1.
  rmw_hazard_chk #(
    .ADDR_W  (ADDR_W),
    .entry_t (pipe_stage_t)
  ) u_hazard_chk (
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .older    (st[NUM_STAGES-2:0]),
    .hazard   (hazard)
  );

  assign in_ready = ~hazard;
  assign accept   = in_valid & in_ready;
  assign s3_inc   = st[2].data + DATA_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= '0;
    end else begin
      st[0] <= pipe_stage_t'{valid: accept, addr: in_addr, data: '0};
      st[1] <= st[0];
      st[2] <= pipe_stage_t'{valid: st[1].valid, addr: st[1].addr, data: mem_rd_data};
      st[3] <= pipe_stage_t'{valid: st[2].valid, addr: st[2].addr, data: s3_inc};
    end
  end

  assign mem_rd_addr = st[0].addr;
  assign mem_rd_en   = st[0].valid;
  assign mem_wr_en   = st[3].valid;
  assign mem_wr_addr = st[3].addr;
  assign mem_wr_data = st[3].data;
  assign done_valid  = st[3].valid;
  assign done_addr   = st[3].addr;
  assign done_data   = st[3].data;
  assign busy        = st[0].valid | st[1].valid | st[2].valid | st[3].valid;

`ifdef RMW_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rmw_pipe_ctrl.sv
// Directed-vector bench for rmw_pipe_ctrl with a behavioural dual-port memory (read-old-data).
module tb_rmw_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_addr = '0;
  logic [3:0]  mem_rd_addr;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_data = '0;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_addr;
  logic [3:0]  mem_wr_data;
  logic        done_valid;
  logic [3:0]  done_addr;
  logic [3:0]  done_data;
  logic        busy;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  rmw_pipe_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .done_valid  (done_valid),
    .done_addr   (done_addr),
    .done_data   (done_data),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: port 0 registered read returning pre-edge contents, port 1 write; bench pokes when idle.
  logic [3:0] mem [16];
  logic       poke_we = 1'b0;
  logic [3:0] poke_addr = '0;
  logic [3:0] poke_data = '0;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (poke_we) mem[poke_addr] <= poke_data;
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [3:0] data;
    logic [3:0] daddr;
    logic [3:0] ddata;
    logic       dvalid;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1)
      wq.push_back('{cyc, mem_wr_addr, mem_wr_data, done_addr, done_data, done_valid});
  end

  function automatic logic [39:0] all_outs();
    return {mem_rd_addr, mem_rd_en, mem_wr_en, mem_wr_addr, mem_wr_data,
            done_valid, done_addr, done_data, busy, stall_cnt};
  endfunction

  task automatic poke(input logic [3:0] a, input logic [3:0] d);
    poke_we = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_we = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wq.delete();
  endtask

  // Present one op, hold it until accepted; returns stall cycles and the post-accept cycle index (op in S1).
  task automatic offer(input logic [3:0] a, output int stalls, output int acc);
    in_valid = 1'b1;
    in_addr  = a;
    stalls   = 0;
    #1;
    while (in_ready !== 1'b1 && stalls < 20) begin
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    while (wq.size() < n && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    int s, a;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #2;
    n_vec++;
    if (all_outs() !== 40'h0) begin
      n_err++; $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 16; i++) poke(4'(i), 4'(i));
    wq.delete();
    offer(4'd1, s, a);
    offer(4'd2, s, a);
    offer(4'd3, s, a);
    @(posedge clk); #1;
    n_vec++;
    if ({mem_wr_en, mem_wr_addr, busy} !== {1'b1, 4'd1, 1'b1}) begin
      n_err++; $display("FAIL midstream_s4: got %b/%h/%b expected 1/1/1", mem_wr_en, mem_wr_addr, busy);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== 40'h0) begin
      n_err++; $display("FAIL midstream_reset_outs: got %h expected 0", all_outs());
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midstream_reset_ready: got %b expected 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (wq.size() !== 0) begin
      n_err++; $display("FAIL reset_no_write: got %0d writes expected 0", wq.size());
    end
    n_vec++;
    if (mem[1] !== 4'd1) begin
      n_err++; $display("FAIL reset_mem1: got %h expected 1", mem[1]);
    end
  endtask

  task automatic test_distinct();
    int s;
    int acc [4];
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      offer(4'(i), s, acc[i]);
      n_vec++;
      if (s !== 0) begin
        n_err++; $display("FAIL distinct_ready[%0d]: got %0d stalls expected 0", i, s);
      end
    end
    wait_writes(4);
    n_vec++;
    if (wq.size() !== 4) begin
      n_err++; $display("FAIL distinct_count: got %0d expected 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if ({wq[i].addr, wq[i].data, wq[i].daddr, wq[i].ddata, wq[i].dvalid}
            !== {4'(i), 4'(i + 1), 4'(i), 4'(i + 1), 1'b1}) begin
          n_err++;
          $display("FAIL distinct_wr[%0d]: got a=%h d=%h da=%h dd=%h dv=%b expected a=%h d=%h",
                   i, wq[i].addr, wq[i].data, wq[i].daddr, wq[i].ddata, wq[i].dvalid, i, i + 1);
        end
        n_vec++;
        if (wq[i].cyc !== acc[0] + 3 + i) begin
          n_err++; $display("FAIL distinct_cyc[%0d]: got %0d expected %0d", i, wq[i].cyc, acc[0] + 3 + i);
        end
      end
    end
  endtask

  task automatic test_raw();
    int s0, s1, a0, a1;
    poke(4'd3, 4'd5);
    wq.delete();
    offer(4'd3, s0, a0);
    offer(4'd3, s1, a1);
    n_vec++;
    if (s1 !== 3) begin
      n_err++; $display("FAIL raw_stalls: got %0d expected 3", s1);
    end
    n_vec++;
    if (a1 !== a0 + 4) begin
      n_err++; $display("FAIL raw_accept: got %0d expected %0d", a1, a0 + 4);
    end
    wait_writes(2);
    n_vec++;
    if (wq.size() !== 2) begin
      n_err++; $display("FAIL raw_count: got %0d expected 2", wq.size());
    end else begin
      n_vec++;
      if ({wq[0].data, wq[1].data} !== {4'd6, 4'd7}) begin
        n_err++; $display("FAIL raw_data: got %h,%h expected 6,7", wq[0].data, wq[1].data);
      end
      n_vec++;
      if (wq[1].cyc !== a1 + 3) begin
        n_err++; $display("FAIL raw_cyc: got %0d expected %0d", wq[1].cyc, a1 + 3);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (mem[3] !== 4'd7) begin
      n_err++; $display("FAIL raw_mem3: got %h expected 7", mem[3]);
    end
  endtask

  task automatic test_wrap();
    int s, a;
    poke(4'd9, 4'hF);
    wq.delete();
    offer(4'd9, s, a);
    wait_writes(1);
    n_vec++;
    if (wq.size() !== 1) begin
      n_err++; $display("FAIL wrap_count: got %0d expected 1", wq.size());
    end else begin
      n_vec++;
      if ({wq[0].data, wq[0].daddr, wq[0].ddata} !== {4'h0, 4'd9, 4'h0}) begin
        n_err++; $display("FAIL wrap_data: got d=%h da=%h dd=%h expected 0/9/0",
                          wq[0].data, wq[0].daddr, wq[0].ddata);
      end
      n_vec++;
      if (wq[0].cyc !== a + 3) begin
        n_err++; $display("FAIL wrap_latency: got %0d expected %0d", wq[0].cyc - a, 3);
      end
    end
  endtask

  task automatic test_distance2();
    int s, a, s3;
    int exp_cnt;
`ifdef RMW_STALL_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    do_reset();
    n_vec++;
    if (stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL dist2_cnt_reset: got %0d expected 0", stall_cnt);
    end
    poke(4'd5, 4'd2);
    poke(4'd6, 4'd8);
    offer(4'd5, s, a);
    offer(4'd6, s, a);
    offer(4'd5, s3, a);
    n_vec++;
    if (s3 !== 2) begin
      n_err++; $display("FAIL dist2_stalls: got %0d expected 2", s3);
    end
    wait_writes(3);
    n_vec++;
    if (wq.size() !== 3) begin
      n_err++; $display("FAIL dist2_count: got %0d expected 3", wq.size());
    end else begin
      n_vec++;
      if ({wq[0].data, wq[1].data, wq[2].data} !== {4'd3, 4'd9, 4'd4}) begin
        n_err++; $display("FAIL dist2_data: got %h,%h,%h expected 3,9,4",
                          wq[0].data, wq[1].data, wq[2].data);
      end
    end
    n_vec++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL dist2_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_bubbles();
    int s, a0, a1;
    logic exp_wr, exp_busy;
    wq.delete();
    offer(4'd10, s, a0);
    @(posedge clk); #1;
    offer(4'd11, s, a1);
    n_vec++;
    if (a1 !== a0 + 2) begin
      n_err++; $display("FAIL bubble_accept: got %0d expected %0d", a1, a0 + 2);
    end
    while (cyc <= a1 + 4) begin
      exp_wr   = (cyc == a0 + 3) || (cyc == a1 + 3);
      exp_busy = (cyc <= a1 + 3);
      n_vec++;
      if ({mem_wr_en, busy} !== {exp_wr, exp_busy}) begin
        n_err++; $display("FAIL bubble_cyc%0d: got wr=%b busy=%b expected wr=%b busy=%b",
                          cyc - a0, mem_wr_en, busy, exp_wr, exp_busy);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (wq.size() !== 2) begin
      n_err++; $display("FAIL bubble_count: got %0d expected 2", wq.size());
    end else begin
      n_vec++;
      if ({wq[0].data, wq[1].data} !== {4'd11, 4'd12}) begin
        n_err++; $display("FAIL bubble_data: got %h,%h expected b,c", wq[0].data, wq[1].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_raw();
    test_wrap();
    test_distance2();
    test_bubbles();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
